mixcolumns_iter: RTL and testbench

MIXCOLUMNS_ITER -- requirements
Module: mixcolumns_iter

---
 rtl/mixcolumns_iter_if.sv | 20 ++
 rtl/mixcolumns_iter.sv | 130 +++++++++++++
 tb/tb_mixcolumns_iter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mixcolumns_iter_if.sv
// rtl/mixcolumns_iter_if.sv - request/result bundle for the iterative MixColumns block
interface mixcolumns_iter_if;
  logic         start;
  logic         inv;
  logic [127:0] in;
  logic [127:0] key;
  logic         finish;
  logic         busy;
  logic [127:0] mixcolumns;

  modport master (
    output start, inv, in, key,
    input  finish, busy, mixcolumns
  );

  modport slave (
    input  start, inv, in, key,
    output finish, busy, mixcolumns
  );
endinterface

// File: rtl/mixcolumns_iter.sv
// rtl/mixcolumns_iter.sv - AES (Inv)MixColumns plus round-key add, COLS_PER_CYCLE columns per edge
module mixcolumns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  mixcolumns_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] STEP_W = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] cap_in;
  logic [127:0] cap_key;
  logic         cap_inv;
  logic [127:0] work;
  logic [127:0] work_next;
  logic [127:0] result;
  logic         finish_q;
  logic         busy_q;
  logic         use_inv;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse coefficients built from x2/x4/x8: 9=8+1, 11=8+2+1, 13=8+4+1, 14=8+4+2.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_sel);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv_sel) begin
        r[8*i +: 8] = (x8[i] ^ x4[i] ^ x2[i])
                    ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                    ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                    ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end else begin
        r[8*i +: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    return r;
  endfunction

  assign use_inv = INV_EN ? cap_inv : 1'b0;

  always_comb begin
    logic [1:0] idx;
    work_next = work;
    idx       = cnt;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx = cnt + 2'(k);
      work_next[{idx, 5'b0} +: 32] = mix_col(cap_in[{idx, 5'b0} +: 32], use_inv)
                                   ^ cap_key[{idx, 5'b0} +: 32];
    end
  end

  // result only moves on the completing edge, so aborted partial work never shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      cap_in   <= 128'h0;
      cap_key  <= 128'h0;
      cap_inv  <= 1'b0;
      work     <= 128'h0;
      result   <= 128'h0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cap_in  <= bus.in;
            cap_key <= bus.key;
            cap_inv <= bus.inv;
            cnt     <= 2'd0;
            state   <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (!bus.start) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            work <= work_next;
            cnt  <= cnt + STEP_W;
            if (cnt == LAST_CNT) begin
              state    <= DONE;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
              result   <= work_next;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            state    <= IDLE;
            finish_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          finish_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.finish     = finish_q;
  assign bus.busy       = busy_q;
  assign bus.mixcolumns = result;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// tb/tb_mixcolumns_iter.sv - directed checks of mixcolumns_iter at 1, 2 and 4 columns per cycle
module tb_mixcolumns_iter;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         inv;
  logic [127:0] in_v;
  logic [127:0] key_v;

  logic         fin [3];
  logic         bsy [3];
  logic [127:0] mix [3];

  int checks;
  int errors;

  localparam logic [127:0] FWD_IN  = 128'h455313db_455313db_455313db_455313db;
  localparam logic [127:0] FWD_OUT = 128'hbca14d8e_bca14d8e_bca14d8e_bca14d8e;
  localparam logic [127:0] INV_IN  = 128'h9d58dc9f_bca14d8e_01010101_c6c6c6c6;
  localparam logic [127:0] INV_OUT = 128'h5c220af2_455313db_01010101_c6c6c6c6;
  localparam logic [127:0] KA_IN   = 128'h01010101_01010101_01010101_01010101;
  localparam logic [127:0] KA_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] KA_OUT  = 128'h3d4ece088914f6aaa7d3af2917147f2a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcolumns_iter_if bus ();
    mixcolumns_iter #(.COLS_PER_CYCLE(1 << g), .INV_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign bus.start = start;
    assign bus.inv   = inv;
    assign bus.in    = in_v;
    assign bus.key   = key_v;
    assign fin[g]    = bus.finish;
    assign bsy[g]    = bus.busy;
    assign mix[g]    = bus.mixcolumns;
  end

  task automatic chk(input string tag, input int g, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed %h expected %h", tag, 1 << g, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds start for 7 edges; edge 1 is the capture. busy follows edges 1..4/N, finish from edge 4/N+1.
  task automatic wait_done(input string tag, input logic [127:0] prior, input logic [127:0] exp,
                           input bit alter);
    int   rises [3];
    logic prev  [3];
    for (int g = 0; g < 3; g++) begin
      rises[g] = 0;
      prev[g]  = fin[g];
    end
    for (int e = 1; e <= 7; e++) begin
      step();
      if (alter && e == 1) begin
        in_v  = ~in_v;
        key_v = key_v ^ 128'h0f0f_1234_5678_9abc_def0_1357_2468_ace0;
        inv   = ~inv;
      end
      for (int g = 0; g < 3; g++) begin
        int  ncyc;
        bit  exp_fin;
        ncyc    = 4 >> g;
        exp_fin = (e >= ncyc + 1);
        chk({tag, " busy"},   g, 128'(bsy[g]), 128'(e <= ncyc));
        chk({tag, " finish"}, g, 128'(fin[g]), 128'(exp_fin));
        chk({tag, " mix"},    g, mix[g], exp_fin ? exp : prior);
        if (fin[g] && !prev[g]) rises[g]++;
        prev[g] = fin[g];
      end
    end
    for (int g = 0; g < 3; g++) chk({tag, " rises"}, g, 128'(rises[g]), 128'd1);
    start = 1'b0;
    step();
    for (int g = 0; g < 3; g++) begin
      chk({tag, " drop finish"}, g, 128'(fin[g]), 128'd0);
      chk({tag, " drop busy"},   g, 128'(bsy[g]), 128'd0);
      chk({tag, " drop mix"},    g, mix[g], exp);
    end
  endtask

  task automatic run_op(input string tag, input logic i_inv, input logic [127:0] i_in,
                        input logic [127:0] i_key, input logic [127:0] prior,
                        input logic [127:0] exp, input bit alter);
    inv   = i_inv;
    in_v  = i_in;
    key_v = i_key;
    start = 1'b1;
    wait_done(tag, prior, exp, alter);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    inv    = 1'b0;
    in_v   = 128'h0;
    key_v  = 128'h0;
    rst_n  = 1'b0;
    #3;
    for (int g = 0; g < 3; g++) begin
      chk("reset finish", g, 128'(fin[g]), 128'd0);
      chk("reset busy",   g, 128'(bsy[g]), 128'd0);
      chk("reset mix",    g, mix[g], 128'h0);
    end
    step();
    rst_n = 1'b1;
    step();

    run_op("fwd",    1'b0, FWD_IN, 128'h0,  128'h0,   FWD_OUT, 1'b0);
    run_op("inv",    1'b1, INV_IN, 128'h0,  FWD_OUT,  INV_OUT, 1'b0);
    run_op("keyadd", 1'b0, KA_IN,  KA_KEY,  INV_OUT,  KA_OUT,  1'b0);
    run_op("alter",  1'b0, FWD_IN, 128'h0,  KA_OUT,   FWD_OUT, 1'b1);

    // Abort: start drops before the first processing edge.
    inv   = 1'b1;
    in_v  = INV_IN;
    key_v = 128'h0;
    start = 1'b1;
    step();
    for (int g = 0; g < 3; g++) chk("abort capture busy", g, 128'(bsy[g]), 128'd1);
    start = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      for (int g = 0; g < 3; g++) begin
        chk("abort finish", g, 128'(fin[g]), 128'd0);
        chk("abort busy",   g, 128'(bsy[g]), 128'd0);
        chk("abort mix",    g, mix[g], FWD_OUT);
      end
    end
    run_op("post abort", 1'b0, KA_IN, KA_KEY, FWD_OUT, KA_OUT, 1'b0);

    // Asynchronous reset between edges while an operation is in flight.
    inv   = 1'b0;
    in_v  = FWD_IN;
    key_v = 128'h0;
    start = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("async finish", g, 128'(fin[g]), 128'd0);
      chk("async busy",   g, 128'(bsy[g]), 128'd0);
      chk("async mix",    g, mix[g], 128'h0);
    end
    #1;
    rst_n = 1'b1;
    wait_done("restart", 128'h0, FWD_OUT, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
